// File: rtl/lsu_half_pkg.sv
// Shared types and constants for the halfword load/store unit.
package lsu_half_pkg;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned XLEN   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_t;

endpackage

// File: rtl/lsu_half_agen.sv
// Effective-address generation for lsu_half: rs1 + imm plus fault detection.
// Build option LSU_HALF_TRAP_EN: when defined, misaligned or out-of-range
// addresses raise a fault; otherwise the address is forced into the legal range.
module lsu_half_agen
    import lsu_half_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] addr,
    output logic            fault
);

    logic [XLEN-1:0] sum;

    // Modular add; the carry out of bit 31 is discarded.
    assign sum = base + offset;

`ifdef LSU_HALF_TRAP_EN
    assign addr  = sum;
    assign fault = sum[0] | (|sum[XLEN-1:ADDR_BITS]);
`else
    // Clear bit 0 and everything above the backed address range.
    localparam logic [XLEN-1:0] LegalMask =
        {{(XLEN - ADDR_BITS){1'b0}}, {(ADDR_BITS - 1){1'b1}}, 1'b0};

    assign addr  = sum & LegalMask;
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/lsu_half.sv
// Halfword-only load/store unit: one lh/sh per transaction, three cycles each
// (IDLE -> ACCESS -> RESP). Fault behaviour depends on LSU_HALF_TRAP_EN,
// which is consumed only inside lsu_half_agen.
module lsu_half
    import lsu_half_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            mem_we_half,
    output logic            mem_re_half,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            exc_valid,
    output logic [XLEN-1:0] exc_addr
);

    state_t state_q, state_d;

    logic [XLEN-1:0]   addr_q;
    logic [HALF_W-1:0] wdata_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [4:0]        rd_q;
    logic              is_store_q;
    logic              fault_q;

    logic [XLEN-1:0]   agen_addr;
    logic              agen_fault;
    logic              accept;
    logic              do_load;

    lsu_half_agen #(
        .ADDR_BITS (ADDR_BITS)
    ) u_agen (
        .base   (rs1_data),
        .offset (imm),
        .addr   (agen_addr),
        .fault  (agen_fault)
    );

    assign accept  = (state_q == StIdle) && req_valid;
    assign do_load = !is_store_q && !fault_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: the only decision is leaving IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Request latch and load-data capture at the edge closing ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
            fault_q    <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            if (accept) begin
                addr_q     <= agen_addr;
                wdata_q    <= rs2_data[HALF_W-1:0];
                rd_q       <= rd_in;
                is_store_q <= req_is_store;
                fault_q    <= agen_fault;
            end
            if ((state_q == StAccess) && do_load) begin
                wb_data_q <= mem_rdata;
            end
        end
    end

    // Outputs decoded from state; strobes and pulses are masked while rst is high
    // so a reset in ACCESS never commits a write.
    always_comb begin
        req_ready   = (state_q == StIdle);
        mem_we_half = 1'b0;
        mem_re_half = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        done        = 1'b0;
        exc_valid   = 1'b0;
        exc_addr    = '0;
        wb_data     = wb_data_q;
        unique case (state_q)
            StAccess: begin
                mem_addr    = addr_q;
                mem_wdata   = {{(XLEN - HALF_W){1'b0}}, wdata_q};
                mem_we_half = !rst && is_store_q && !fault_q;
                mem_re_half = !rst && do_load;
            end
            StResp: begin
                done      = !rst;
                wb_valid  = !rst && do_load && (rd_q != 5'd0);
                wb_rd     = do_load ? rd_q : 5'd0;
                exc_valid = !rst && fault_q;
                exc_addr  = fault_q ? addr_q : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_half.sv
// Self-checking bench for lsu_half: directed cases plus randomized lh/sh traffic
// checked against a halfword-array reference memory.
module tb_lsu_half;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [31:0] rs1_data;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        mem_we_half;
    logic        mem_re_half;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        exc_valid;
    logic [31:0] exc_addr;

    int tests = 0;
    int fails = 0;

    // Data memory device seen by the DUT, and the bench's own expectation of it.
    logic [15:0] dev_mem [512] = '{default: 16'h0000};
    logic [15:0] ref_mem [512] = '{default: 16'h0000};

    lsu_half #(
        .ADDR_BITS (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .rs1_data     (rs1_data),
        .imm          (imm),
        .rs2_data     (rs2_data),
        .rd_in        (rd_in),
        .mem_we_half  (mem_we_half),
        .mem_re_half  (mem_re_half),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .done         (done),
        .exc_valid    (exc_valid),
        .exc_addr     (exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = {{16{dev_mem[mem_addr[9:1]][15]}}, dev_mem[mem_addr[9:1]]};

    always @(posedge clk) begin
        if (mem_we_half) dev_mem[mem_addr[9:1]] <= mem_wdata[15:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction with per-cycle checks against the reference model.
    task automatic run_txn(input bit st, input logic [31:0] r1, input logic [31:0] im,
                           input logic [31:0] r2, input logic [4:0] rd);
        logic [31:0] ea;
        bit          flt;
        logic [31:0] exp_data;
        int          n;
        ea = r1 + im;
`ifdef LSU_HALF_TRAP_EN
        flt = ea[0] || ((ea >> 10) != 0);
`else
        ea  = ea & 32'h0000_03FE;
        flt = 1'b0;
`endif
        exp_data = {{16{ref_mem[ea[9:1]][15]}}, ref_mem[ea[9:1]]};

        n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_before_req", {31'b0, req_ready}, 32'd1);

        req_valid    = 1'b1;
        req_is_store = st;
        rs1_data     = r1;
        imm          = im;
        rs2_data     = r2;
        rd_in        = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        // ACCESS cycle
        check("access_ready", {31'b0, req_ready}, 32'd0);
        check("access_we", {31'b0, mem_we_half}, {31'b0, st && !flt});
        check("access_re", {31'b0, mem_re_half}, {31'b0, !st && !flt});
        check("access_done", {31'b0, done}, 32'd0);
        if (!flt) check("access_addr", mem_addr, ea);
        if (st && !flt) check("access_wdata", {16'b0, mem_wdata[15:0]}, {16'b0, r2[15:0]});
        if (st && !flt) ref_mem[ea[9:1]] = r2[15:0];

        @(posedge clk);
        #1;
        // RESP cycle
        check("resp_done", {31'b0, done}, 32'd1);
        check("resp_we", {31'b0, mem_we_half}, 32'd0);
        check("resp_wb_valid", {31'b0, wb_valid}, {31'b0, !st && !flt && rd != 5'd0});
        check("resp_exc_valid", {31'b0, exc_valid}, {31'b0, flt});
        check("resp_mem_addr", mem_addr, 32'd0);
        if (flt) check("resp_exc_addr", exc_addr, ea);
        if (!st && !flt && rd != 5'd0) begin
            check("resp_wb_rd", {27'b0, wb_rd}, {27'b0, rd});
            check("resp_wb_data", wb_data, exp_data);
        end

        @(posedge clk);
        #1;
        check("back_idle_ready", {31'b0, req_ready}, 32'd1);
        check("back_idle_done", {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] im;
        int          bad;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        rs1_data     = '0;
        imm          = '0;
        rs2_data     = '0;
        rd_in        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_we", {31'b0, mem_we_half}, 32'd0);
        check("rst_re", {31'b0, mem_re_half}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_exc", {31'b0, exc_valid}, 32'd0);
        check("rst_exc_addr", exc_addr, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Store then load, lower half negative.
        run_txn(1'b1, 32'h40, 32'd4, 32'h1234_ABCD, 5'd0);
        run_txn(1'b0, 32'h44, 32'd0, 32'h0, 5'd5);
        // Upper half, positive; then recheck the lower half.
        run_txn(1'b1, 32'h46, 32'd0, 32'h0000_7FFF, 5'd0);
        run_txn(1'b0, 32'h40, 32'd6, 32'h0, 5'd7);
        run_txn(1'b0, 32'h44, 32'd0, 32'h0, 5'd8);
        // Address wrap to 0x2.
        run_txn(1'b1, 32'h0, 32'd2, 32'h0000_8001, 5'd0);
        run_txn(1'b0, 32'hFFFF_FFFE, 32'd4, 32'h0, 5'd9);
        // Misaligned store, then read 0x40.
        run_txn(1'b1, 32'h41, 32'd0, 32'h0000_5555, 5'd0);
        run_txn(1'b0, 32'h40, 32'd0, 32'h0, 5'd10);
        // Out-of-range load and load to x0.
        run_txn(1'b0, 32'h400, 32'd0, 32'h0, 5'd11);
        run_txn(1'b0, 32'h44, 32'd0, 32'h0, 5'd0);

        // Randomized traffic concentrated in a small window so loads hit stores.
        for (int i = 0; i < 80; i++) begin
            r1 = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) r1[0] = 1'b0;
            im = 32'($urandom_range(0, 40)) - 32'd20;
            run_txn(1'($urandom_range(0, 1)), r1, im, 32'($urandom), 5'($urandom_range(0, 31)));
        end

        // Reset during the ACCESS of a store must drop the write.
        run_txn(1'b1, 32'h10, 32'd0, 32'h0000_1357, 5'd0);
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        rs1_data     = 32'h10;
        imm          = 32'd0;
        rs2_data     = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_access_we", {31'b0, mem_we_half}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_abort_ready", {31'b0, req_ready}, 32'd1);
        check("rst_abort_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_abort_done2", {31'b0, done}, 32'd0);
        run_txn(1'b0, 32'h10, 32'd0, 32'h0, 5'd3);

        // No stray writes anywhere in memory.
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (dev_mem[i] !== ref_mem[i]) bad++;
        end
        check("memory_image", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_half.md
# lsu_half

Load/store unit for the halfword-only data path: accepts one `lh`/`sh` request per transaction from the execute stage and computes the effective address (`rs1 + imm`). It then drives the halfword data memory for exactly one access cycle and returns sign-extended load data to writeback. It sits directly upstream of the data memory, consumes its combinational `lh_signed` output, and is the only master of its write/read strobes.

## Interface
Parameters:
- `ADDR_BITS`, 10: byte-address width backed by memory (256 words); addresses ≥ 2^ADDR_BITS are out of range.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_is_store` in 1: 1 = `sh`, 0 = `lh`.
- `rs1_data` in 32: base address.
- `imm` in 32: sign-extended offset.
- `rs2_data` in 32: store data; bits [15:0] are stored.
- `rd_in` in 5: load destination register.
- `mem_we_half` out 1: halfword write strobe to memory.
- `mem_re_half` out 1: halfword read strobe.
- `mem_addr` out 32: byte address to memory.
- `mem_wdata` out 32: store data to memory.
- `mem_rdata` in 32: sign-extended halfword from memory (combinational on `mem_addr`).
- `wb_valid` out 1: load result valid (one-cycle pulse).
- `wb_rd` out 5: load destination.
- `wb_data` out 32: load result.
- `done` out 1: transaction complete (one-cycle pulse, loads, stores and faults).
- `exc_valid` out 1: access fault (one-cycle pulse).
- `exc_addr` out 32: faulting effective address.

## Operation
- States: IDLE → ACCESS → RESP → IDLE, unconditional after IDLE.
- IDLE: `req_ready`=1. On `req_valid`: latch `addr = rs1_data + imm` (32-bit modular, carry discarded), `rs2_data`, `rd_in` and `req_is_store`. Then go to ACCESS.
- Fault check on the latched address: `addr[0]`=1 (misaligned) or `addr[31:ADDR_BITS]`≠0 (out of range).
- ACCESS, no fault:
  - `mem_addr`=addr and `mem_wdata`=stored data.
  - Store: `mem_we_half`=1, so the memory writes at the edge closing ACCESS.
  - Load: `mem_re_half`=1, and `mem_rdata` is captured into `wb_data` at that edge.
- ACCESS, faulted: both strobes stay 0 and memory is untouched.
- RESP: `done`=1.
  - Load without fault: `wb_valid`=1 and `wb_rd`=latched rd. If rd=0, `wb_valid`=0 (x0 is never written), but `done` still pulses.
  - Fault: `exc_valid`=1, `exc_addr`=addr, `wb_valid`=0.
- Strobes are decoded from state and gated with `!rst`, so a reset sampled in ACCESS suppresses the write.
- `req_valid` outside IDLE is ignored (no queueing). The requester holds the request until `req_ready`.

## Timing
- Accept at edge k. ACCESS occupies cycle k..k+1. `wb_valid`/`done`/`exc_valid` are high for cycle k+1..k+2. Back in IDLE after edge k+2.
- Throughput: one transaction per 3 cycles. A new request is accepted at edge k+3 at the earliest.
- Reset values: state IDLE, `req_ready`=1 after reset. All other outputs are 0: `mem_*`, `wb_*`, `done`, `exc_*`.
- Reset in any state returns to IDLE at the next edge and aborts the transaction. No `done` pulse is produced.
- `mem_addr`/`mem_wdata` are 0 outside ACCESS.

## Configuration
- `LSU_HALF_TRAP_EN` defined: faults behave as above.
- Undefined: no fault detection and `exc_valid`/`exc_addr` are tied to 0. The address is forced legal: bit 0 is cleared and bits [31:ADDR_BITS] are zeroed. The access then proceeds normally.

## Structure
- Package `lsu_half_pkg`: state enum (IDLE, ACCESS, RESP), localparams `HALF_W`=16 and `XLEN`=32.
- Sub-module `lsu_half_agen`: combinational `rs1+imm` plus fault/masking logic. This is the only place that uses `LSU_HALF_TRAP_EN`.

## Test plan
- Store then load: `sh` rs1=0x40, imm=4, rs2=0x1234_ABCD → memory word 0x44 [15:0]=0xABCD. Then `lh` from 0x44, rd=5 → `wb_valid` at k+2, `wb_data`=0xFFFF_ABCD, `wb_rd`=5.
- Upper half: `sh` to 0x46 with 0x7FFF, then `lh` 0x46 → `wb_data`=0x0000_7FFF, lower half unchanged.
- Address wrap: rs1=0xFFFF_FFFE, imm=4 → `mem_addr`=0x2. Load returns memory content at 0x2.
- Misaligned `sh` to 0x41 with trap enabled → `mem_we_half` never 1, `exc_valid`=1 with `exc_addr`=0x41, `done`=1. Same access with trap disabled → write to 0x40.
- `lh` with rd=0 → `done`=1, `wb_valid`=0.
- `rst` asserted during the ACCESS of a store → no write, IDLE next cycle, no `done`. A subsequent load of that address returns the old value.
